// File: rtl/rename_freelist_pkg.sv
// Shared rename-stage definitions: tag and pointer types, sizing constants and
// mask popcount helpers used by the physical-register free list.
package rename_freelist_pkg;

  localparam int PHYS_W       = 7;
  localparam int NUM_PHYS     = 128;
  localparam int NUM_ARCH     = 32;
  localparam int RENAME_WIDTH = 4;
  localparam int FL_DEPTH     = 128;
  localparam int FL_IDX_W     = $clog2(FL_DEPTH);
  localparam int PTR_W        = FL_IDX_W + 1;
  localparam int FL_INIT      = NUM_PHYS - NUM_ARCH;

  typedef logic [PHYS_W-1:0] phys_tag_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) c = c + {2'b00, m[i]};
    return c;
  endfunction

  // Number of set bits strictly below bit k; at most 3, so it fits in 2 bits.
  function automatic logic [1:0] prefix_cnt4(input logic [3:0] m, input int k);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < k) c = c + {2'b00, m[i]};
    end
    return c[1:0];
  endfunction

endpackage

// File: rtl/rename_prefix_cnt.sv
// Compacts a 4-slot request mask: per-slot offset among the set slots below it,
// plus the total number of set slots.
module rename_prefix_cnt
  import rename_freelist_pkg::*;
(
  input  logic [RENAME_WIDTH-1:0]      mask,
  output logic [RENAME_WIDTH-1:0][1:0] offset,
  output logic [2:0]                   total
);

  always_comb begin
    offset = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      offset[k] = prefix_cnt4(mask, k);
    end
  end

  assign total = popcount4(mask);

endmodule

// File: rtl/rename_freelist.sv
// Physical-register free list for the 4-wide rename stage: circular buffer of
// free tags with speculative head, committed head for flush recovery, and tail.
module rename_freelist
  import rename_freelist_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      alloc_req_i,
  output logic            alloc_ok_o,
  output phys_tag_t       alloc_phys0_o,
  output phys_tag_t       alloc_phys1_o,
  output phys_tag_t       alloc_phys2_o,
  output phys_tag_t       alloc_phys3_o,
  input  logic [3:0]      free_vld_i,
  input  phys_tag_t       free_phys0_i,
  input  phys_tag_t       free_phys1_i,
  input  phys_tag_t       free_phys2_i,
  input  phys_tag_t       free_phys3_i,
  input  logic [2:0]      commit_cnt_i,
  input  logic            flush_i,
  output logic [7:0]      free_cnt_o,
  output logic            err_o
);

  // Handshake: alloc_ok_o acts as ready for the whole alloc_req_i mask; the
  // request is consumed only on an edge where alloc_ok_o=1 and flush_i=0,
  // otherwise rename must hold it. Frees and commits have no back-pressure.

  phys_tag_t  entry_q [FL_DEPTH];
  fl_ptr_t    head_q, commit_head_q, tail_q;
  fl_ptr_t    head_next, commit_next, tail_next;
  fl_ptr_t    free_room, outstanding;
  logic [7:0] cnt_q;
  logic       err_q, err_set;

  logic [3:0][1:0] alloc_off, free_off;
  logic [2:0]      alloc_n, free_m;
  phys_tag_t       free_tag  [RENAME_WIDTH];
  phys_tag_t       alloc_tag [RENAME_WIDTH];
  logic [FL_IDX_W-1:0] alloc_idx [RENAME_WIDTH];
  logic [FL_IDX_W-1:0] free_idx  [RENAME_WIDTH];

  rename_prefix_cnt u_alloc_cnt (.mask(alloc_req_i), .offset(alloc_off), .total(alloc_n));
  rename_prefix_cnt u_free_cnt  (.mask(free_vld_i),  .offset(free_off),  .total(free_m));

  assign free_tag[0] = free_phys0_i;
  assign free_tag[1] = free_phys1_i;
  assign free_tag[2] = free_phys2_i;
  assign free_tag[3] = free_phys3_i;

  assign alloc_phys0_o = alloc_tag[0];
  assign alloc_phys1_o = alloc_tag[1];
  assign alloc_phys2_o = alloc_tag[2];
  assign alloc_phys3_o = alloc_tag[3];

  // Uses the registered count, so tags freed this cycle are not yet visible.
  assign alloc_ok_o = (cnt_q >= PTR_W'(alloc_n));
  assign free_cnt_o = cnt_q;
  assign err_o      = err_q;

  always_comb begin
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      alloc_idx[k] = head_q[FL_IDX_W-1:0] + FL_IDX_W'(alloc_off[k]);
      free_idx[k]  = tail_q[FL_IDX_W-1:0] + FL_IDX_W'(free_off[k]);
      alloc_tag[k] = entry_q[alloc_idx[k]];
    end
  end

  always_comb begin
    commit_next = commit_head_q + PTR_W'(commit_cnt_i);
    tail_next   = tail_q + PTR_W'(free_m);
    head_next   = head_q;
    if (flush_i)         head_next = commit_next;
    else if (alloc_ok_o) head_next = head_q + PTR_W'(alloc_n);
    free_room   = tail_next - commit_next;
    outstanding = head_q - commit_head_q;
    err_set     = ((free_m != 3'd0) && (free_room > PTR_W'(FL_INIT)))
               || (PTR_W'(commit_cnt_i) > outstanding)
               || (commit_cnt_i > 3'(RENAME_WIDTH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry_q[i] <= (i < FL_INIT) ? PHYS_W'(NUM_ARCH + i) : '0;
      end
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= PTR_W'(FL_INIT);
      cnt_q         <= 8'(FL_INIT);
      err_q         <= 1'b0;
    end else begin
      for (int k = 0; k < RENAME_WIDTH; k++) begin
        if (free_vld_i[k]) entry_q[free_idx[k]] <= free_tag[k];
      end
      head_q        <= head_next;
      commit_head_q <= commit_next;
      tail_q        <= tail_next;
      cnt_q         <= tail_next - head_next;
      err_q         <= err_q | err_set;
    end
  end

endmodule

// File: tb/tb_rename_freelist.sv
// Directed bench for rename_freelist: stimulus pushes expected observations into
// a queue, a negedge monitor pops and compares them against the DUT outputs.
module tb_rename_freelist;
  import rename_freelist_pkg::*;

  localparam logic [1:0] K_OK = 2'd0, K_PH = 2'd1, K_CNT = 2'd2, K_ERR = 2'd3;

  typedef struct packed {
    logic [15:0] cyc;
    logic [1:0]  kind;
    logic [1:0]  slot;
    logic [7:0]  val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alloc_req = '0;
  logic       alloc_ok;
  phys_tag_t  alloc_phys [4];
  logic [3:0] free_vld = '0;
  phys_tag_t  free_phys0 = '0, free_phys1 = '0, free_phys2 = '0, free_phys3 = '0;
  logic [2:0] commit_cnt = '0;
  logic       flush = 1'b0;
  logic [7:0] free_cnt;
  logic       err;

  exp_t exp_q[$];
  exp_t e;
  logic [7:0] act;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rename_freelist dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_req_i(alloc_req), .alloc_ok_o(alloc_ok),
    .alloc_phys0_o(alloc_phys[0]), .alloc_phys1_o(alloc_phys[1]),
    .alloc_phys2_o(alloc_phys[2]), .alloc_phys3_o(alloc_phys[3]),
    .free_vld_i(free_vld),
    .free_phys0_i(free_phys0), .free_phys1_i(free_phys1),
    .free_phys2_i(free_phys2), .free_phys3_i(free_phys3),
    .commit_cnt_i(commit_cnt), .flush_i(flush),
    .free_cnt_o(free_cnt), .err_o(err)
  );

  function automatic string kind_name(input logic [1:0] k);
    case (k)
      K_OK:    return "alloc_ok";
      K_PH:    return "alloc_phys";
      K_CNT:   return "free_cnt";
      default: return "err";
    endcase
  endfunction

  // One cycle of stimulus, applied just after the active edge.
  task automatic drive(input logic r, input logic [3:0] req, input logic [3:0] fv,
                       input logic [27:0] tags, input logic [2:0] cc, input logic fl);
    @(posedge clk);
    #1;
    rst = r; alloc_req = req; free_vld = fv; commit_cnt = cc; flush = fl;
    {free_phys3, free_phys2, free_phys1, free_phys0} = tags;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 28'h0, 3'd0, 1'b0);
  endtask

  task automatic expect_v(input logic [1:0] kind, input int slot, input int val);
    exp_t x;
    x.cyc = 16'(cyc); x.kind = kind; x.slot = 2'(slot); x.val = 8'(val);
    exp_q.push_back(x);
  endtask

  // Reset is held while alloc/free/flush are all active to show it overrides them.
  task automatic do_reset();
    drive(1'b1, 4'hf, 4'hf, 28'h1234567, 3'd4, 1'b1);
    drive(1'b1, 4'hf, 4'hf, 28'h1234567, 3'd4, 1'b1);
    expect_v(K_CNT, 0, 96);
    expect_v(K_ERR, 0, 0);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_OK:    act = {7'b0, alloc_ok};
        K_PH:    act = {1'b0, alloc_phys[e.slot]};
        K_CNT:   act = free_cnt;
        default: act = {7'b0, err};
      endcase
      checks++;
      if (int'(e.cyc) != cyc || act !== e.val) begin
        errors++;
        $display("FAIL %s slot=%0d cyc=%0d actual=%0d required=%0d (at cyc %0d)",
                 kind_name(e.kind), e.slot, e.cyc, act, e.val, cyc);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    // Basic allocation and compaction
    do_reset();
    drive(1'b0, 4'b1111, 4'h0, 28'h0, 3'd0, 1'b0);
    expect_v(K_OK, 0, 1);  expect_v(K_CNT, 0, 96); expect_v(K_ERR, 0, 0);
    expect_v(K_PH, 0, 32); expect_v(K_PH, 1, 33);
    expect_v(K_PH, 2, 34); expect_v(K_PH, 3, 35);
    drive(1'b0, 4'b1010, 4'h0, 28'h0, 3'd0, 1'b0);
    expect_v(K_OK, 0, 1);  expect_v(K_CNT, 0, 92);
    expect_v(K_PH, 1, 36); expect_v(K_PH, 3, 37);
    for (int i = 0; i < 22; i++) begin
      drive(1'b0, 4'b1111, 4'h0, 28'h0, 3'd0, 1'b0);
      expect_v(K_PH, 0, 38 + 4 * i);
      expect_v(K_CNT, 0, 90 - 4 * i);
    end
    // Two left: three-slot request stalls, retire 4 meanwhile
    drive(1'b0, 4'b0111, 4'h0, 28'h0, 3'd4, 1'b0);
    expect_v(K_OK, 0, 0);  expect_v(K_CNT, 0, 2);
    drive(1'b0, 4'b0011, 4'h0, 28'h0, 3'd0, 1'b0);
    expect_v(K_CNT, 0, 2); expect_v(K_OK, 0, 1);
    expect_v(K_PH, 0, 126); expect_v(K_PH, 1, 127);
    // Empty: frees this cycle are not allocatable until next
    drive(1'b0, 4'b0001, 4'b1111, {7'd8, 7'd7, 7'd6, 7'd5}, 3'd0, 1'b0);
    expect_v(K_CNT, 0, 0); expect_v(K_OK, 0, 0);
    drive(1'b0, 4'b0001, 4'h0, 28'h0, 3'd0, 1'b0);
    expect_v(K_CNT, 0, 4); expect_v(K_OK, 0, 1); expect_v(K_PH, 0, 5);
    idle();
    expect_v(K_CNT, 0, 3); expect_v(K_ERR, 0, 0);

    // Flush restores head to committed position
    do_reset();
    drive(1'b0, 4'b1111, 4'h0, 28'h0, 3'd0, 1'b0);
    expect_v(K_PH, 0, 32); expect_v(K_PH, 3, 35);
    drive(1'b0, 4'b1111, 4'h0, 28'h0, 3'd0, 1'b0);
    expect_v(K_PH, 0, 36); expect_v(K_PH, 3, 39); expect_v(K_CNT, 0, 92);
    drive(1'b0, 4'b0000, 4'h0, 28'h0, 3'd3, 1'b0);
    expect_v(K_CNT, 0, 88); expect_v(K_ERR, 0, 0);
    drive(1'b0, 4'b1111, 4'h0, 28'h0, 3'd0, 1'b1);
    expect_v(K_CNT, 0, 88); expect_v(K_OK, 0, 1);
    drive(1'b0, 4'b0001, 4'h0, 28'h0, 3'd0, 1'b0);
    expect_v(K_CNT, 0, 93); expect_v(K_OK, 0, 1); expect_v(K_PH, 0, 35);
    idle();
    expect_v(K_CNT, 0, 92); expect_v(K_ERR, 0, 0);

    // Overflow on free is sticky until reset
    do_reset();
    drive(1'b0, 4'b0000, 4'b0001, {21'd0, 7'd50}, 3'd0, 1'b0);
    expect_v(K_CNT, 0, 96); expect_v(K_ERR, 0, 0);
    idle();
    expect_v(K_ERR, 0, 1); expect_v(K_CNT, 0, 97);
    idle();
    idle();
    expect_v(K_ERR, 0, 1);

    // Commit beyond outstanding allocations
    do_reset();
    drive(1'b0, 4'b0000, 4'h0, 28'h0, 3'd1, 1'b0);
    expect_v(K_ERR, 0, 0);
    idle();
    expect_v(K_ERR, 0, 1);

    // Commit count above four with enough outstanding allocations
    do_reset();
    drive(1'b0, 4'b1111, 4'h0, 28'h0, 3'd0, 1'b0);
    drive(1'b0, 4'b1111, 4'h0, 28'h0, 3'd0, 1'b0);
    drive(1'b0, 4'b0000, 4'h0, 28'h0, 3'd5, 1'b0);
    expect_v(K_ERR, 0, 0);
    idle();
    expect_v(K_ERR, 0, 1); expect_v(K_CNT, 0, 88);

    idle();
    idle();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
